led_pio_write_arbiter: RTL and testbench



---
 rtl/led_ctrl_pkg.sv | 14 +
 rtl/led_pio_write_arbiter_if.sv | 26 ++
 rtl/led_rr_arbiter.sv | 36 +++
 rtl/led_pio_write_arbiter.sv | 126 ++++++++++++
 tb/tb_led_pio_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED PIO write arbiter.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DWELL = 2'd3
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int         PIO_DATA_W    = 8;

endpackage

// File: rtl/led_pio_write_arbiter_if.sv
// Avalon-MM slave port of the LED PIO, driven by the arbiter in place of a CPU master.
interface led_pio_write_arbiter_if;

    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;

    modport master (
        output pio_address,
        output pio_chipselect,
        output pio_write_n,
        output pio_writedata,
        input  pio_readdata
    );

    modport slave (
        input  pio_address,
        input  pio_chipselect,
        input  pio_write_n,
        input  pio_writedata,
        output pio_readdata
    );

endinterface

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin pick: first set req bit above last_grant, wrapping.
module led_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        idx         = '0;
        if (en) begin
            for (int i = NUM_REQ; i >= 1; i--) begin
                sum = {1'b0, last_grant} + (IDX_W+1)'(i);
                if (sum >= (IDX_W+1)'(NUM_REQ))
                    sum = sum - (IDX_W+1)'(NUM_REQ);
                idx = sum[IDX_W-1:0];
                if (req[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/led_pio_write_arbiter.sv
// Round-robin arbiter issuing single LED PIO writes with a post-write dwell.
// Optional readback check after each write: define LED_PIO_READBACK_EN.
//
// state | meaning
// IDLE  | waiting for a registered request; grant taken on leaving
// WRITE | one-cycle PIO write of latched value, ack pulses
// READ  | one-cycle PIO read, compared with latched value (macro only)
// DWELL | hold-off so the pattern stays visible, requests ignored
module led_pio_write_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int DWELL_CYCLES = 1000,
    parameter int DATA_W       = PIO_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic                      err_mismatch,
    led_pio_write_arbiter_if.master   pio
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW_W  = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);
    localparam state_t POST_ACCESS = (DWELL_CYCLES > 0) ? DWELL : IDLE;

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  req_q;
    logic [IDX_W-1:0]    last_grant;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   sel_data;
    logic [DW_W-1:0]     dwell_cnt;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;
    logic                unused_readdata;

    // req is registered first so no output depends combinationally on it.
    led_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .en          (state == IDLE),
        .req         (req_q),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_data     = '0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_data        = req_data[i*DATA_W +: DATA_W];
                grant_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = WRITE;
`ifdef LED_PIO_READBACK_EN
            WRITE:   state_nxt = READ;
`else
            WRITE:   state_nxt = POST_ACCESS;
`endif
            READ:    state_nxt = POST_ACCESS;
            DWELL:   if (dwell_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from state_nxt so they line up with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            req_q              <= '0;
            last_grant         <= IDX_W'(NUM_REQ - 1);
            data_q             <= '0;
            dwell_cnt          <= '0;
            ack                <= '0;
            busy               <= 1'b0;
            pio.pio_chipselect <= 1'b0;
            pio.pio_write_n    <= 1'b1;
            pio.pio_writedata  <= '0;
        end else begin
            state <= state_nxt;
            req_q <= req;
            if (state == IDLE && grant_valid) begin
                last_grant        <= grant_idx;
                data_q            <= sel_data;
                pio.pio_writedata <= {{(32-DATA_W){1'b0}}, sel_data};
                ack               <= grant_onehot;
            end else begin
                ack <= '0;
            end
            if (state != DWELL && state_nxt == DWELL)
                dwell_cnt <= DWELL_LOAD;
            else if (state == DWELL && dwell_cnt != '0)
                dwell_cnt <= dwell_cnt - 1'b1;
            busy               <= (state_nxt != IDLE);
            pio.pio_chipselect <= (state_nxt == WRITE) || (state_nxt == READ);
            pio.pio_write_n    <= (state_nxt != WRITE);
        end
    end

    assign pio.pio_address = PIO_DATA_ADDR;
    assign unused_readdata = ^pio.pio_readdata;

`ifdef LED_PIO_READBACK_EN
    // Zero-wait-state PIO: read data is valid during the READ cycle itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_mismatch <= 1'b0;
        else if (state == READ && pio.pio_readdata[DATA_W-1:0] != data_q)
            err_mismatch <= 1'b1;
    end
`else
    assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Scoreboard bench for led_pio_write_arbiter (NUM_REQ=3, DWELL_CYCLES=4, DATA_W=8).
module tb_led_pio_write_arbiter;
    import led_ctrl_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int DWELL   = 4;
`ifdef LED_PIO_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int GAP = 2 + DWELL + RB;

    typedef struct {
        logic [2:0] ack;
        logic [7:0] data;
        int         at;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  ack;
    logic        busy;
    logic        err_mismatch;
    logic [7:0]  pio_reg = 8'h00;
    logic        pio_bad = 1'b0;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_cnt = 0;
    int   cyc = 0;
    int   last_wr = 0;

    led_pio_write_arbiter_if pio ();

    led_pio_write_arbiter #(.NUM_REQ(NUM_REQ), .DWELL_CYCLES(DWELL), .DATA_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .busy         (busy),
        .err_mismatch (err_mismatch),
        .pio          (pio.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Zero-wait PIO data register; pio_bad forces a wrong readback.
    always @(posedge clk) begin
        if (pio.pio_chipselect && !pio.pio_write_n)
            pio_reg <= pio.pio_writedata[7:0];
    end
    assign pio.pio_readdata = pio_bad ? 32'h0 : {24'h0, pio_reg};

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic expect_write(logic [2:0] a, logic [7:0] d, int at, int gap);
        exp_t e;
        e.ack = a; e.data = d; e.at = at; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_writes(int target, int budget);
        int n = 0;
        #1;
        while (wr_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (wr_cnt < target) begin
            n_vec++; n_err++;
            $display("FAIL write_timeout: got %0d writes, required %0d", wr_cnt, target);
        end
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        #1;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: busy got %b, required 0", busy);
        end
    endtask

    // Monitor: every PIO write pops one expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (pio.pio_chipselect === 1'b1 && pio.pio_write_n === 1'b0) begin
                wr_cnt++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got data %0h ack %b, required no write", pio.pio_writedata, ack);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (pio.pio_writedata !== {24'h0, e.data} || ack !== e.ack || pio.pio_address !== 2'd0) begin
                        n_err++;
                        $display("FAIL write_data: got data %0h ack %b addr %0d, required data %0h ack %b addr 0",
                                 pio.pio_writedata, ack, pio.pio_address, e.data, e.ack);
                    end
                    if (e.at >= 0) begin
                        n_vec++;
                        if (cyc != e.at) begin
                            n_err++;
                            $display("FAIL write_latency: got cycle %0d, required %0d", cyc, e.at);
                        end
                    end
                    if (e.gap > 0) begin
                        n_vec++;
                        if (cyc - last_wr != e.gap) begin
                            n_err++;
                            $display("FAIL write_spacing: got %0d, required %0d", cyc - last_wr, e.gap);
                        end
                    end
                end
                last_wr = cyc;
            end else if (ack !== 3'b000) begin
                n_vec++; n_err++;
                $display("FAIL stray_ack: got %b, required 000", ack);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (5) @(negedge clk);
        check("rst_cs",    {31'b0, pio.pio_chipselect}, 32'd0);
        check("rst_wr_n",  {31'b0, pio.pio_write_n}, 32'd1);
        check("rst_wdata", pio.pio_writedata, 32'd0);
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_ack",   {29'b0, ack}, 32'd0);
        check("rst_err",   {31'b0, err_mismatch}, 32'd0);
        reset_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_quiet", {28'b0, pio.pio_chipselect, pio.pio_write_n, busy, |ack}, 32'h4);
        end

        // Single request from requester 1
        @(negedge clk);
        req = 3'b010; req_data[15:8] = 8'hA5;
        expect_write(3'b010, 8'hA5, cyc + 2, 0);
        w0 = wr_cnt;
        wait_writes(w0 + 1, 20);
        req = 3'b000;
        for (int k = 1; k <= DWELL + RB + 1; k++) begin
            @(negedge clk);
            check("busy_dwell", {31'b0, busy}, (k <= DWELL + RB) ? 32'd1 : 32'd0);
        end

        // Fresh start, then round-robin with all requesters held
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        req = 3'b111; req_data = {8'h33, 8'h22, 8'h11};
        expect_write(3'b001, 8'h11, cyc + 2, 0);
        expect_write(3'b010, 8'h22, -1, GAP);
        expect_write(3'b100, 8'h33, -1, GAP);
        expect_write(3'b001, 8'h11, -1, GAP);
        w0 = wr_cnt;
        wait_writes(w0 + 4, 80);
        req = 3'b000;
        wait_idle(20);

        // Data captured at grant; req dropped before ack
        @(negedge clk);
        req = 3'b001; req_data[7:0] = 8'h0F;
        expect_write(3'b001, 8'h0F, cyc + 2, 0);
        w0 = wr_cnt;
        @(negedge clk); req = 3'b000;
        @(negedge clk); req_data[7:0] = 8'hF0;
        wait_writes(w0 + 1, 10);
        wait_idle(20);
        repeat (8) @(negedge clk);

        // Reset in the middle of a write
        @(negedge clk);
        req = 3'b100; req_data[23:16] = 8'h77;
        expect_write(3'b100, 8'h77, cyc + 2, 0);
        w0 = wr_cnt;
        wait_writes(w0 + 1, 10);
        reset_n = 1'b0; req = 3'b000;
        #1;
        check("midrst_cs",   {31'b0, pio.pio_chipselect}, 32'd0);
        check("midrst_wr_n", {31'b0, pio.pio_write_n}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_ack",  {29'b0, ack}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        req = 3'b111; req_data = {8'hCC, 8'hBB, 8'hAA};
        expect_write(3'b001, 8'hAA, cyc + 2, 0);
        w0 = wr_cnt;
        wait_writes(w0 + 1, 10);
        req = 3'b000;
        wait_idle(20);

`ifdef LED_PIO_READBACK_EN
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            d = 8'(i * 23 + 3);
            @(negedge clk);
            req = 3'b001; req_data[7:0] = d;
            expect_write(3'b001, d, cyc + 2, 0);
            w0 = wr_cnt;
            wait_writes(w0 + 1, 10);
            req = 3'b000;
            wait_idle(20);
            check("rb_good_err", {31'b0, err_mismatch}, 32'd0);
        end
        pio_bad = 1'b1;
        @(negedge clk);
        req = 3'b001; req_data[7:0] = 8'h5A;
        expect_write(3'b001, 8'h5A, cyc + 2, 0);
        w0 = wr_cnt;
        wait_writes(w0 + 1, 10);
        req = 3'b000;
        wait_idle(20);
        check("rb_bad_err", {31'b0, err_mismatch}, 32'd1);
        pio_bad = 1'b0;
        @(negedge clk);
        req = 3'b001; req_data[7:0] = 8'h3C;
        expect_write(3'b001, 8'h3C, cyc + 2, 0);
        w0 = wr_cnt;
        wait_writes(w0 + 1, 10);
        req = 3'b000;
        wait_idle(20);
        check("rb_sticky_err", {31'b0, err_mismatch}, 32'd1);
`else
        check("err_tied_low", {31'b0, err_mismatch}, 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
